// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache/bus requesters.
// One transaction in flight; a watchdog aborts transactions stuck in RAM BUSY.
module ram_arbiter #(
    parameter int NREQ    = 4,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NREQ-1:0]            req_REN,
    input  logic [NREQ-1:0]            req_WEN,
    input  logic [NREQ*WORD_W-1:0]     req_addr,
    input  logic [NREQ*WORD_W-1:0]     req_store,
    output logic [NREQ-1:0]            req_wait,
    output logic [WORD_W-1:0]          req_load,
    output logic [NREQ-1:0]            req_err,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [WORD_W-1:0]          ramaddr,
    output logic [WORD_W-1:0]          ramstore,
    input  logic [WORD_W-1:0]          ramload,
    input  logic [1:0]                 ramstate,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       arb_busy
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {RAM_FREE = 2'b00, RAM_BUSY = 2'b01,
                              RAM_ACCESS = 2'b10, RAM_ERROR = 2'b11} ram_state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   tcount_q, tcount_d;

    logic [NREQ-1:0]    req_any;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   rr_next;
    logic               gnt_active, done_ok, done_err, done_to, done_any;
    int                 scan_idx;

    assign req_any    = req_REN | req_WEN;
    assign gnt_active = (state_q == BUSY) && req_any[grant_q];
    assign done_ok    = gnt_active && (ramstate == RAM_ACCESS);
    assign done_err   = gnt_active && (ramstate == RAM_ERROR);
    assign done_to    = gnt_active && !done_ok && !done_err && (tcount_q == T_LAST);
    assign done_any   = done_ok | done_err | done_to;
    assign rr_next    = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick     = rr_ptr_q;
        scan_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_any[scan_idx]) pick = IDX_W'(scan_idx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before this edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tcount_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tcount_q <= tcount_d;
        end
    end

    // NOTE: every next-state variable takes its hold value first, so no
    // path through the case leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        tcount_d = tcount_q;
        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    grant_d  = pick;
                    tcount_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (tcount_q != T_LAST) tcount_d = tcount_q + 1'b1;
                if (!gnt_active) begin
                    state_d = IDLE;
                end else if (done_any) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_wait = '1;
        req_err  = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == BUSY) begin
            ramaddr  = req_addr[int'(grant_q)*WORD_W +: WORD_W];
            ramstore = req_store[int'(grant_q)*WORD_W +: WORD_W];
        end
        if (gnt_active) begin
            // A write takes precedence when both enables are raised.
            ramWEN = req_WEN[grant_q];
            ramREN = req_REN[grant_q] & ~req_WEN[grant_q];
        end
        if (done_any)            req_wait[grant_q] = 1'b0;
        if (done_err | done_to)  req_err[grant_q]  = 1'b1;
    end

    assign req_load = ramload;
    assign grant_id = grant_q;
    assign arb_busy = (state_q == BUSY);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level arbitration model.
module tb_ram_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int TO   = 8;
    localparam logic [1:0] S_FREE = 2'b00, S_BUSY = 2'b01, S_ACC = 2'b10, S_ERR = 2'b11;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req_REN, req_WEN, req_wait, req_err;
    logic [NREQ*W-1:0]   req_addr, req_store;
    logic [W-1:0]        req_load, ramaddr, ramstore, ramload;
    logic                ramREN, ramWEN, arb_busy;
    logic [1:0]          ramstate;
    logic [1:0]          grant_id;

    int total = 0;
    int bad   = 0;
    int model_rr = 0;
    logic [W-1:0] addr_v [NREQ];
    logic [W-1:0] store_v[NREQ];
    logic         use_fixed = 1'b0;
    logic [W-1:0] fixed_load = '0;

    ram_arbiter #(.NREQ(NREQ), .WORD_W(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_REN(req_REN), .req_WEN(req_WEN),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load), .req_err(req_err),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_id(grant_id), .arb_busy(arb_busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic randomize_bus();
        for (int i = 0; i < NREQ; i++) begin
            addr_v[i]  = $urandom;
            store_v[i] = $urandom;
        end
    endtask

    task automatic pack_bus();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*W +: W]  = addr_v[i];
            req_store[i*W +: W] = store_v[i];
        end
    endtask

    // Model: the first requester at or after the round-robin pointer wins.
    function automatic int model_pick(logic [NREQ-1:0] m, int rr);
        for (int k = 0; k < NREQ; k++)
            if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        logic [127:0] obs, exp;
        obs = {arb_busy, ramREN, ramWEN, ramaddr, ramstore, req_wait, req_err};
        exp = {1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, {NREQ{1'b1}}, {NREQ{1'b0}}};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s idle: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called in the cycle before arbitration. Holds ren/wen for the whole
    // transaction; the RAM answers 'fin' after busy_cycles BUSY cycles, or
    // the watchdog fires if that comes too late.
    task automatic run_txn(input logic [NREQ-1:0] ren, input logic [NREQ-1:0] wen,
                           input int busy_cycles, input logic [1:0] fin,
                           input string tag, output int obs_g);
        int g;
        logic ended, is_err;
        logic [NREQ-1:0] ew, ee;
        logic [159:0] obs, exp;
        req_REN = ren; req_WEN = wen; pack_bus();
        ramstate = S_FREE;
        obs_g = -1;
        g = model_pick(ren | wen, model_rr);
        @(negedge CLK);
        check_idle(tag);
        @(posedge CLK); #1;
        for (int c = 1; c <= TO; c++) begin
            ramstate = (c == busy_cycles + 1) ? fin : S_BUSY;
            ramload  = use_fixed ? fixed_load : $urandom;
            ended  = (ramstate == S_ACC) || (ramstate == S_ERR) || (c == TO);
            is_err = (ramstate == S_ERR) || (ramstate != S_ACC && c == TO);
            ew = '1; ee = '0;
            if (ended) ew[g] = 1'b0;
            if (is_err) ee[g] = 1'b1;
            @(negedge CLK);
            if (c == 1) obs_g = int'(grant_id);
            obs = {arb_busy, grant_id, ramREN, ramWEN, ramaddr, ramstore, req_wait, req_err, req_load};
            exp = {1'b1, 2'(g), ren[g] & ~wen[g], wen[g], addr_v[g], store_v[g], ew, ee, ramload};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %h want %h", tag, c, obs, exp);
            end
            @(posedge CLK); #1;
            if (ended) begin
                model_rr = (g + 1) % NREQ;
                ramstate = S_FREE;
                break;
            end
        end
    endtask

    task automatic pulse_reset(input int cycles);
        RST = 1'b1; req_REN = '0; req_WEN = '0; ramstate = S_FREE; ramload = '0;
        repeat (cycles) @(posedge CLK);
        #1 RST = 1'b0;
        model_rr = 0;
    endtask

    task automatic test_reset();
        logic [127:0] obs, exp;
        RST = 1'b1; req_REN = '0; req_WEN = '0; ramstate = S_FREE; ramload = '0;
        randomize_bus(); pack_bus();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        obs = {grant_id, arb_busy, ramREN, ramWEN, ramaddr, ramstore, req_wait, req_err};
        exp = {2'b00, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, {NREQ{1'b1}}, {NREQ{1'b0}}};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", obs, exp);
        end
        @(posedge CLK); #1 RST = 1'b0;
        model_rr = 0;
    endtask

    task automatic test_single_read();
        int g;
        randomize_bus();
        addr_v[0] = 32'h40;
        use_fixed = 1'b1; fixed_load = 32'hDEADBEEF;
        run_txn(4'b0001, 4'b0000, 2, S_ACC, "single_read", g);
        use_fixed = 1'b0;
        req_REN = '0;
        @(negedge CLK);
        total++;
        if (arb_busy !== 1'b0 || g !== 0) begin
            bad++;
            $display("FAIL single_read_after: arb_busy=%b grant=%0d want 0 and 0", arb_busy, g);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_round_robin();
        int g;
        int exp_a[5] = '{0, 1, 2, 3, 0};
        int exp_b[4] = '{2, 3, 0, 2};
        pulse_reset(1);
        for (int i = 0; i < 5; i++) begin
            randomize_bus();
            run_txn(4'b1111, 4'b0000, 0, S_ACC, "rr_all", g);
            total++;
            if (g !== exp_a[i]) begin
                bad++;
                $display("FAIL rr_all order[%0d]: got %0d want %0d", i, g, exp_a[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            randomize_bus();
            run_txn(4'b1101, 4'b0000, 0, S_ACC, "rr_drop1", g);
            total++;
            if (g !== exp_b[i]) begin
                bad++;
                $display("FAIL rr_drop1 order[%0d]: got %0d want %0d", i, g, exp_b[i]);
            end
        end
    endtask

    task automatic test_write_precedence();
        int g;
        randomize_bus();
        addr_v[2] = 32'h100; store_v[2] = 32'h12345678;
        run_txn(4'b0100, 4'b0100, 1, S_ACC, "write_prec", g);
        total++;
        if (g !== 2) begin
            bad++;
            $display("FAIL write_prec grant: got %0d want 2", g);
        end
    endtask

    task automatic test_timeout();
        int g, g2, want;
        randomize_bus();
        run_txn(4'(1 << $urandom_range(0, NREQ - 1)), 4'b0000, 100, S_BUSY, "timeout", g);
        want = (g + 1) % NREQ;
        randomize_bus();
        run_txn(4'b1111, 4'b0000, 0, S_ACC, "timeout_next", g2);
        total++;
        if (g2 !== want) begin
            bad++;
            $display("FAIL timeout_rr_advance: got %0d want %0d", g2, want);
        end
    endtask

    task automatic test_abort();
        int a, g;
        logic [127:0] obs, exp;
        a = model_rr;
        randomize_bus(); pack_bus();
        req_REN = 4'(1 << a); req_WEN = '0; ramstate = S_BUSY;
        @(posedge CLK); #1;
        repeat (2) @(posedge CLK);
        #1 req_REN = '0;
        @(negedge CLK);
        obs = {arb_busy, ramREN, ramWEN, req_wait, req_err};
        exp = {1'b1, 1'b0, 1'b0, {NREQ{1'b1}}, {NREQ{1'b0}}};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL abort_cycle: got %h want %h", obs, exp);
        end
        @(posedge CLK); #1;
        ramstate = S_FREE;
        @(negedge CLK);
        total++;
        if (arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_to_idle: arb_busy=%b want 0", arb_busy);
        end
        @(posedge CLK); #1;
        randomize_bus();
        run_txn(4'b1111, 4'b0000, 0, S_ACC, "abort_next", g);
        total++;
        if (g !== a) begin
            bad++;
            $display("FAIL abort_rr_unchanged: got %0d want %0d", g, a);
        end
    endtask

    task automatic test_error();
        int g;
        for (int i = 0; i < 3; i++) begin
            randomize_bus();
            run_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, TO - 2), S_ERR, "ram_error", g);
        end
    endtask

    task automatic test_random();
        int g;
        logic [1:0] fins[4] = '{S_ACC, S_ERR, S_ACC, S_BUSY};
        for (int i = 0; i < 25; i++) begin
            randomize_bus();
            run_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, TO + 1), fins[$urandom_range(0, 3)], "random", g);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        randomize_bus(); pack_bus();
        req_REN = 4'b1000; req_WEN = '0; ramstate = S_BUSY;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_rr = 0;
        total++;
        if (grant_id !== 2'd0 || arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: grant=%0d busy=%b want 0 and 0", grant_id, arb_busy);
        end
        randomize_bus();
        run_txn(4'b1111, 4'b0000, 0, S_ACC, "reset_mid_next", g);
    endtask

    initial begin
        req_REN = '0; req_WEN = '0; ramstate = S_FREE; ramload = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_precedence();
        test_timeout();
        test_abort();
        test_error();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port among NREQ requesters: per-core icache/dcache ports and the coherence bus.
- Sits between the multicore processor's cache ports and the memory mux.
- Round-robin arbitration, with one outstanding RAM transaction at a time.
- Per-requester wait handshake, plus a watchdog that aborts stalled transactions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORD_W, 32, address/data width.
- TIMEOUT, 64, maximum BUSY cycles before abort (>=2).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- req_REN  in  NREQ  per-requester read request.
- req_WEN  in  NREQ  per-requester write request.
- req_addr  in  NREQ*WORD_W  packed addresses; requester i occupies bits [i*WORD_W +: WORD_W].
- req_store  in  NREQ*WORD_W  packed write data, same packing as req_addr.
- req_wait  out  NREQ  per-requester stall; low means the access completed this cycle.
- req_load  out  WORD_W  read data (valid for the requester whose req_wait is low).
- req_err  out  NREQ  one-cycle pulse: the transaction ended in RAM ERROR or timeout.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM state: FREE=00, BUSY=01, ACCESS=10, ERROR=11.
- grant_id  out  $clog2(NREQ)  current/last granted requester.
- arb_busy  out  1  high while in state BUSY.

Behaviour:
- Request definition: requester i is requesting when req_REN[i] | req_WEN[i].
- If both REN and WEN are high for a requester, WEN wins: ramWEN=1, ramREN=0.
- States: IDLE and BUSY. Registers: state, grant_id, rr_ptr, tcount.
- Reset (RST=1 at a CLK edge):
  - state=IDLE, grant_id=0, rr_ptr=0, tcount=0.
  - Outputs: req_wait=all 1s (high for every requester with an active request; bits of inactive requesters are don't-care but are driven 1), req_err=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, arb_busy=0.
  - Reset mid-transaction drops the RAM request on the next cycle, with no completion or error signalled.
- IDLE:
  - RAM enables are 0; req_wait=all 1s.
  - If any request is pending, choose the first requesting index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register that index into grant_id, clear tcount, go to BUSY.
  - The arbitration cycle is never skipped.
- BUSY:
  - ramREN/ramWEN/ramaddr/ramstore are driven combinationally from requester grant_id.
  - tcount increments every BUSY cycle.
- Transitions out of BUSY, in priority order:
  1. Granted requester drops both REN and WEN: abort. RAM enables go 0 that cycle, go to IDLE, rr_ptr unchanged, no wait or err pulse.
  2. ramstate==ACCESS: req_wait[grant_id]=0 combinationally in the same cycle, req_load=ramload. Go to IDLE, rr_ptr=(grant_id+1) mod NREQ.
  3. ramstate==ERROR: req_wait[grant_id]=0 and req_err[grant_id]=1 for that cycle. Go to IDLE and advance rr_ptr.
  4. tcount==TIMEOUT-1 with none of the above: req_wait[grant_id]=0 and req_err[grant_id]=1. Go to IDLE and advance rr_ptr.
- Non-granted requesters keep req_wait=1 throughout.
- Latency: minimum 2 cycles from request to completion (1 arbitration cycle + 1 RAM ACCESS cycle). Each further RAM busy cycle adds 1.
- Fairness: after completing a transaction, requester k cannot be granted again until every other requester that was continuously requesting has been served once. Starvation bound is NREQ transactions.
- req_load must equal ramload whenever any req_wait bit is low; it is otherwise don't-care, but driven from ramload.
- Modular arithmetic: rr_ptr wraps at NREQ (wraps to 0 when NREQ is not a power of two). tcount saturates and is cleared on entry to BUSY.
- No combinational path from ramstate to any RAM enable, except through the abort/complete logic described above.

Test Plan:
1. Reset and single read:
   - Stimulus: RST for 2 cycles. Then req_REN[0]=1, addr=0x40. RAM returns ACCESS on the 3rd BUSY cycle with ramload=0xDEADBEEF.
   - Required: ramREN=1, ramaddr=0x40 from cycle 2. req_wait[0]=0 and req_load=0xDEADBEEF exactly in the ACCESS cycle. arb_busy=0 the next cycle.
2. Round-robin:
   - Stimulus: all 4 requesters hold REN continuously; RAM gives ACCESS after 1 cycle each time.
   - Required: grant order 0,1,2,3,0.
   - Stimulus: requester 1 deasserts after being served.
   - Required: order continues 2,3,0,2.
3. Write precedence:
   - Stimulus: requester 2 raises REN and WEN together, addr=0x100, store=0x12345678.
   - Required: ramWEN=1, ramREN=0, ramstore=0x12345678.
4. Timeout:
   - Stimulus: TIMEOUT=8, ramstate stuck at BUSY.
   - Required: on the 8th BUSY cycle, req_wait[g]=0 and req_err[g]=1 for one cycle, then IDLE, and rr_ptr advances.
5. Abort and error:
   - Stimulus: granted requester drops REN mid-BUSY.
   - Required: RAM enables 0 that cycle, no err pulse, rr_ptr unchanged.
   - Stimulus: ramstate=ERROR.
   - Required: req_err pulse and completion.
6. Reset mid-operation:
   - Stimulus: assert RST during BUSY.
   - Required: all outputs at reset values the next cycle, grant_id=0, no completion pulse.
